display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 64: clk cycles during which all anodes are off after each digit advance.
REQ-002 SHALL have parameter LZ_BLANK, default 1: 1 enables leading-zero blanking.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port scan_clk, input, 1: toggling output of the clock divider, synchronous to clk; each toggle is one scan step.
REQ-006 SHALL have port en, input, 1: 1 enables scanning, 0 blanks the display.
REQ-007 SHALL have port bcd, input, 16: four BCD digits, [3:0] = digit0 (rightmost) .. [15:12] = digit3.
REQ-008 SHALL have port dp, input, 4: decimal point request per digit, bit i = digit i.
REQ-009 SHALL have port an, output, 4: anode enables, active-low, bit i = digit i.
REQ-010 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp_n, output, 1: decimal point, active-low.
REQ-012 SHALL have port digit_idx, output, 2: index of the digit currently selected.

Function
REQ-013 SHALL register scan_clk into scan_q each cycle; step = scan_clk XOR scan_q, so a step is seen one cycle after any toggle.
REQ-014 SHALL ignore step in the first clk cycle after reset release (arming cycle), so a high scan_clk at reset release causes no spurious step.
REQ-015 SHALL implement FSM states IDLE, BLANK and SHOW.
REQ-016 In IDLE, an=4'hF, digit_idx=0; when en=1: snapshot bcd/dp into frame register, go to BLANK with the blank counter at 0.
REQ-017 In BLANK, an=4'hF; the counter increments each cycle; when it reaches BLANK_CYCLES-1, go to SHOW next cycle.
REQ-018 In SHOW, an has only bit digit_idx low; seg/dp_n are driven from the frame register for digit_idx.
REQ-019 Step in SHOW: digit_idx <= digit_idx+1 mod 4, go to BLANK with counter 0.
REQ-020 Step in BLANK: digit_idx still advances and the counter restarts at 0; no step is dropped.
REQ-021 With BLANK_CYCLES=0, a step in SHOW SHALL go directly to SHOW with the new index, and BLANK is never entered after IDLE exit.
REQ-022 On a digit_idx wrap from 3 to 0, the frame register SHALL reload from bcd/dp in the same cycle; no other change in bcd/dp affects the display mid-frame.
REQ-023 Decode: 0-9 standard active-low 7-seg (0 -> 7'b1000000, 8 -> 7'b0000000); 10-15 -> dash 7'b0111111.
REQ-024 If LZ_BLANK=1, digit i (i=1..3) SHALL show seg=7'h7F when its snapshot value and all higher digits are 0 and its dp bit is 0; digit0 is never blanked.
REQ-025 dp_n = ~dp snapshot bit for digit_idx in SHOW, 1 otherwise.
REQ-026 en=0 in any state: next cycle IDLE, an=4'hF, seg=7'h7F, dp_n=1, digit_idx=0.
REQ-027 an, seg, dp_n and digit_idx SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-028 While rst=0: an=4'hF, seg=7'h7F, dp_n=1, digit_idx=0, state IDLE, scan_q=0, counter 0, frame register 0.
REQ-029 Reset assertion mid-SHOW SHALL blank all outputs immediately, without waiting for a clk edge.

Verification
REQ-030 Reset release with en=1, bcd=16'h1234, BLANK_CYCLES=4, scan_clk toggled every 20 cycles -> an cycles 1110,1101,1011,0111 with seg 4,3,2,1, and 4 blank cycles before each digit.
REQ-031 bcd=16'h0050, LZ_BLANK=1 -> digits 3 and 2 seg=7'h7F, digit1 "5", digit0 "0"; with dp[3]=1, digit3 shows "0".
REQ-032 Change bcd 16'h1234 -> 16'h9999 while digit_idx=1 -> digits 1..3 still show 3,2,1; 9s appear after the wrap to 0.
REQ-033 Two scan_clk toggles 2 cycles apart during BLANK -> digit_idx advances by 2 and the counter restarts twice.
REQ-034 Drop en during SHOW -> an=4'hF the next cycle and digit_idx=0; re-raise en -> new snapshot, BLANK, then digit0.
REQ-035 bcd digit value 4'hB -> seg=7'b0111111; rst pulsed low mid-scan -> outputs reach reset values asynchronously.

Source files
------------

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner: one digit lit at a time, with a blank gap
// after every digit advance, a per-frame snapshot of the BCD input and leading-zero blanking.
module display_scan #(
  parameter int unsigned BLANK_CYCLES = 64,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_clk,
  input  logic        en,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [1:0]  digit_idx
);

  localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam bit HAS_BLANK = (BLANK_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      frame_bcd_q, frame_bcd_d;
  logic [3:0]       frame_dp_q, frame_dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_n_q, dp_n_d;
  logic             scan_q;
  logic             armed_q;
  logic             step_c;

  // A toggle of scan_clk is seen as a step; the first cycle after reset is ignored.
  assign step_c = armed_q & (scan_clk ^ scan_q);

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Digit i>0 blanks when it and every digit above it are zero and its point is off.
  function automatic logic lz_hide(input logic [15:0] b, input logic [3:0] d, input logic [1:0] i);
    logic zero_run;
    zero_run = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      zero_run = zero_run & (b[k*4 +: 4] == 4'd0);
      if (k == int'(i)) return zero_run & ~d[k];
    end
    return 1'b0;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_bcd_d = frame_bcd_q;
    frame_dp_d  = frame_dp_q;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_bcd_d = bcd;
          frame_dp_d  = dp;
          cnt_d       = '0;
          idx_d       = '0;
          state_d     = HAS_BLANK ? S_BLANK : S_SHOW;
        end
        S_BLANK: begin
          if (step_c) begin
            idx_d = idx_q + 2'd1;
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_SHOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_SHOW: begin
          if (step_c) begin
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            state_d = HAS_BLANK ? S_BLANK : S_SHOW;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // A new frame is captured only when the scan wraps back to digit 0.
      if (step_c && (state_q != S_IDLE) && (idx_q == 2'd3)) begin
        frame_bcd_d = bcd;
        frame_dp_d  = dp;
      end
    end
  end

  always_comb begin
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (state_d == S_SHOW) begin
      an_d   = ~(4'b0001 << idx_d);
      seg_d  = (LZ_BLANK && lz_hide(frame_bcd_d, frame_dp_d, idx_d)) ? 7'h7F
             : decode(frame_bcd_d[{idx_d, 2'b00} +: 4]);
      dp_n_d = ~frame_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_bcd_q <= '0;
      frame_dp_q  <= '0;
      scan_q      <= 1'b0;
      armed_q     <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_bcd_q <= frame_bcd_d;
      frame_dp_q  <= frame_dp_d;
      scan_q      <= scan_clk;
      armed_q     <= 1'b1;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp_n      = dp_n_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with BLANK_CYCLES=4: scan order, snapshot timing,
// leading-zero blanking, step restarts in BLANK, enable drop and asynchronous reset.
module tb_display_scan;

  logic        clk;
  logic        rst;
  logic        scan_clk;
  logic        en;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_idx;

  int n_checks;
  int n_errors;

  display_scan #(.BLANK_CYCLES(4), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .scan_clk(scan_clk), .en(en), .bcd(bcd), .dp(dp),
    .an(an), .seg(seg), .dp_n(dp_n), .digit_idx(digit_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One scan step: 4 blank cycles with the new index, then the digit is lit.
  task automatic step_show(input string tag, input logic [1:0] e_idx, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dpn);
    scan_clk = ~scan_clk;
    tick(1);
    check_eq({tag, " idx"}, 32'(digit_idx), 32'(e_idx));
    check_eq({tag, " blank an"}, 32'(an), 32'hF);
    tick(3);
    check_eq({tag, " blank end an"}, 32'(an), 32'hF);
    tick(1);
    check_eq({tag, " an"}, 32'(an), 32'(e_an));
    check_eq({tag, " seg"}, 32'(seg), 32'(e_seg));
    check_eq({tag, " dp_n"}, 32'(dp_n), 32'(e_dpn));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    en       = 1'b1;
    bcd      = 16'h1234;
    dp       = 4'h0;
    scan_clk = 1'b1;
    tick(2);
    check_eq("reset an", 32'(an), 32'hF);
    check_eq("reset seg", 32'(seg), 32'h7F);
    check_eq("reset dp_n", 32'(dp_n), 32'h1);
    check_eq("reset idx", 32'(digit_idx), 32'h0);

    // Release with scan_clk high: the arming cycle must swallow the apparent toggle.
    rst = 1'b1;
    tick(1);
    check_eq("arm idx", 32'(digit_idx), 32'h0);
    check_eq("arm blank an", 32'(an), 32'hF);
    tick(3);
    check_eq("first blank an", 32'(an), 32'hF);
    tick(1);
    check_eq("d0 an", 32'(an), 32'hE);
    check_eq("d0 seg", 32'(seg), 32'h19);
    check_eq("d0 idx", 32'(digit_idx), 32'h0);

    step_show("d1", 2'd1, 4'b1101, 7'h30, 1'b1);
    bcd = 16'h9999;
    step_show("snap d2", 2'd2, 4'b1011, 7'h24, 1'b1);
    step_show("snap d3", 2'd3, 4'b0111, 7'h79, 1'b1);
    step_show("wrap9 d0", 2'd0, 4'b1110, 7'h10, 1'b1);
    bcd = 16'h0050;
    step_show("nine d1", 2'd1, 4'b1101, 7'h10, 1'b1);
    step_show("nine d2", 2'd2, 4'b1011, 7'h10, 1'b1);
    step_show("nine d3", 2'd3, 4'b0111, 7'h10, 1'b1);
    step_show("lz d0", 2'd0, 4'b1110, 7'h40, 1'b1);
    step_show("lz d1", 2'd1, 4'b1101, 7'h12, 1'b1);
    step_show("lz d2", 2'd2, 4'b1011, 7'h7F, 1'b1);
    step_show("lz d3", 2'd3, 4'b0111, 7'h7F, 1'b1);
    dp = 4'b1000;
    step_show("dp d0", 2'd0, 4'b1110, 7'h40, 1'b1);
    step_show("dp d1", 2'd1, 4'b1101, 7'h12, 1'b1);
    step_show("dp d2", 2'd2, 4'b1011, 7'h7F, 1'b1);
    step_show("dp d3", 2'd3, 4'b0111, 7'h40, 1'b0);
    bcd = 16'h00B0;
    dp  = 4'h0;
    step_show("dash d0", 2'd0, 4'b1110, 7'h40, 1'b1);
    step_show("dash d1", 2'd1, 4'b1101, 7'h3F, 1'b1);

    // Two steps two cycles apart inside BLANK: index +2, gap restarts from the second.
    scan_clk = ~scan_clk;
    tick(1);
    check_eq("dbl idx a", 32'(digit_idx), 32'h2);
    tick(1);
    scan_clk = ~scan_clk;
    tick(1);
    check_eq("dbl idx b", 32'(digit_idx), 32'h3);
    check_eq("dbl blank an", 32'(an), 32'hF);
    tick(3);
    check_eq("dbl restart an", 32'(an), 32'hF);
    tick(1);
    check_eq("dbl show an", 32'(an), 32'h7);
    check_eq("dbl show seg", 32'(seg), 32'h7F);

    // Enable drop and re-raise.
    en = 1'b0;
    tick(1);
    check_eq("en0 an", 32'(an), 32'hF);
    check_eq("en0 idx", 32'(digit_idx), 32'h0);
    check_eq("en0 seg", 32'(seg), 32'h7F);
    check_eq("en0 dp_n", 32'(dp_n), 32'h1);
    bcd = 16'h0007;
    en  = 1'b1;
    tick(4);
    check_eq("en1 blank an", 32'(an), 32'hF);
    tick(1);
    check_eq("en1 an", 32'(an), 32'hE);
    check_eq("en1 seg", 32'(seg), 32'h78);

    // Asynchronous reset while a digit is lit, checked before the next clock edge.
    tick(2);
    rst = 1'b0;
    #2;
    check_eq("arst an", 32'(an), 32'hF);
    check_eq("arst seg", 32'(seg), 32'h7F);
    check_eq("arst dp_n", 32'(dp_n), 32'h1);
    check_eq("arst idx", 32'(digit_idx), 32'h0);
    tick(1);
    rst = 1'b1;
    tick(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
